// File: rtl/fp_addsub_sched_pkg.sv
// Shared types and constants for the fp_addsub_sched adder scheduler.
package fp_addsub_sched_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned FP_SIGN = 31;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_ops_t;

    // Subtraction is addition with the sign of b inverted.
    function automatic logic [FP_W-1:0] apply_sub(input logic [FP_W-1:0] x, input logic sub);
        return {x[FP_SIGN] ^ sub, x[FP_SIGN-1:0]};
    endfunction

endpackage

// File: rtl/fp_addsub_sched_if.sv
// Request/response bundle between the FP issue points and the adder scheduler.
interface fp_addsub_sched_if;
    import fp_addsub_sched_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic [FP_W-1:0] req0_a;
    logic [FP_W-1:0] req0_b;
    logic            req0_sub;
    logic            req1_valid;
    logic            req1_ready;
    logic [FP_W-1:0] req1_a;
    logic [FP_W-1:0] req1_b;
    logic            req1_sub;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_id;
    logic [FP_W-1:0] resp_s;
    logic            busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_s, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_s, busy
    );

endinterface

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single adder: zero exponent flushes to zero, truncating round,
// overflow saturates to infinity. No NaN/Inf operand handling.
module fp_adder
    import fp_addsub_sched_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] s
);

    // hidden bit + 23 fraction bits + 3 alignment bits
    localparam int unsigned MW = 27;

    logic            a_big;
    logic [FP_W-1:0] w_big;
    logic [FP_W-1:0] w_sml;
    logic [7:0]      e_big;
    logic [7:0]      e_sml;
    logic [7:0]      e_diff;
    logic [MW-1:0]   m_big;
    logic [MW-1:0]   m_sml;
    logic [MW-1:0]   m_sh;
    logic [MW:0]     sum;
    logic [MW-1:0]   norm;
    logic [4:0]      lz;
    logic [9:0]      e_res;
    logic [22:0]     frac;

    always_comb begin
        a_big  = a[FP_SIGN-1:0] >= b[FP_SIGN-1:0];
        w_big  = a_big ? a : b;
        w_sml  = a_big ? b : a;
        e_big  = w_big[30:23];
        e_sml  = w_sml[30:23];
        m_big  = (e_big != 8'd0) ? {1'b1, w_big[22:0], 3'b000} : '0;
        m_sml  = (e_sml != 8'd0) ? {1'b1, w_sml[22:0], 3'b000} : '0;
        e_diff = e_big - e_sml;
        m_sh   = (e_diff >= 8'(MW)) ? '0 : (m_sml >> e_diff);

        if (w_big[FP_SIGN] == w_sml[FP_SIGN]) begin
            sum = {1'b0, m_big} + {1'b0, m_sh};
        end else begin
            sum = {1'b0, m_big} - {1'b0, m_sh};
        end

        lz = '0;
        for (int i = 0; i < int'(MW); i++) begin
            if (sum[i]) lz = 5'(int'(MW) - 1 - i);
        end
        norm = sum[MW-1:0] << lz;

        if (sum[MW]) begin
            frac  = sum[MW-1:MW-23];
            e_res = 10'(e_big) + 10'd1;
        end else begin
            frac  = norm[MW-2:MW-24];
            e_res = 10'(e_big) - 10'(lz);
        end

        // Exact cancellation is +0 unless both inputs were negative.
        if (sum == '0) begin
            s = {w_big[FP_SIGN] & w_sml[FP_SIGN], 31'd0};
        end else if (e_res[9] || (e_res == 10'd0)) begin
            s = {w_big[FP_SIGN], 31'd0};
        end else if (e_res >= 10'd255) begin
            s = {w_big[FP_SIGN], 8'hFF, 23'd0};
        end else begin
            s = {w_big[FP_SIGN], e_res[7:0], frac};
        end
    end

endmodule

// File: rtl/fp_addsub_sched_arb.sv
// Two-requester round-robin grant; ptr names the requester favoured on contention.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    output logic grant,
    output logic any
);

    assign any   = valid0 | valid1;
    assign grant = !(valid0 && (!valid1 || !ptr));

endmodule

// File: rtl/fp_addsub_sched.sv
// Shares one combinational fp_adder between two requesters: round-robin accept,
// hold operands for SETTLE_CYCLES clocks, then return the sum on a tagged response.
module fp_addsub_sched
    import fp_addsub_sched_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    fp_addsub_sched_if.slave   bus
);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fp_ops_t         op_q, op_d;
    logic            id_q, id_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic            resp_id_q, resp_id_d;
    logic [FP_W-1:0] resp_s_q, resp_s_d;
    logic [FP_W-1:0] add_s;
    logic            grant;
    logic            any_valid;
    logic            req0_ready_c;
    logic            req1_ready_c;

    rr_arb2 u_arb (
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .ptr    (rr_ptr_q),
        .grant  (grant),
        .any    (any_valid)
    );

    // Adder sees only the held operand registers: multicycle path from op_q to resp_s_q.
    fp_adder u_add (
        .a (op_q.a),
        .b (op_q.b),
        .s (add_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            id_q      <= 1'b0;
            rr_ptr_q  <= 1'b0;
            resp_id_q <= 1'b0;
            resp_s_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            id_q      <= id_d;
            rr_ptr_q  <= rr_ptr_d;
            resp_id_q <= resp_id_d;
            resp_s_q  <= resp_s_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        id_d         = id_q;
        rr_ptr_d     = rr_ptr_q;
        resp_id_d    = resp_id_q;
        resp_s_d     = resp_s_q;
        req0_ready_c = 1'b0;
        req1_ready_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req0_ready_c = bus.req0_valid && !grant;
                req1_ready_c = bus.req1_valid && grant;
                if (any_valid) begin
                    op_d.a   = grant ? bus.req1_a : bus.req0_a;
                    op_d.b   = grant ? apply_sub(bus.req1_b, bus.req1_sub)
                                     : apply_sub(bus.req0_b, bus.req0_sub);
                    id_d     = grant;
                    rr_ptr_d = ~grant;
                    cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    resp_s_d  = add_s;
                    resp_id_d = id_q;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req0_ready = req0_ready_c;
    assign bus.req1_ready = req1_ready_c;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.resp_s     = resp_s_q;
    assign bus.resp_id    = resp_id_q;

endmodule
